fib_seq_ctrl: RTL and testbench

//  Parametrised Fibonacci-class sequencer FSM driving the register-file/ALU datapath.

---
 rtl/fib_seq_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_fib_seq_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_ctrl.sv
// Fibonacci-class sequencer: emits one registered control word per cycle for the
// register-file/ALU datapath, with start/busy/done handshake, seed modes and stall.
`timescale 1ns/1ps

module fib_seq_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int ALU_OP_W = 8,
  parameter int IMM_W    = 16,
  parameter int CNT_W    = 8,
  parameter logic [ALU_OP_W-1:0] OP_NOP  = 8'h00,
  parameter logic [ALU_OP_W-1:0] OP_ADD  = 8'h05,
  parameter logic [ALU_OP_W-1:0] OP_MOVI = 8'h0B,
  localparam int SEL_W = $clog2(NUM_REGS),
  localparam int MUX_W = 2*SEL_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                hold,
  input  logic [CNT_W-1:0]    n_terms,
  input  logic [1:0]          mode,
  input  logic [IMM_W-1:0]    seed0,
  input  logic [IMM_W-1:0]    seed1,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [MUX_W-1:0]    muxes,
  output logic [NUM_REGS-1:0] regs_en,
  output logic [IMM_W-1:0]    imm,
  output logic [CNT_W-1:0]    term_idx,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED0,
    S_SEED1,
    S_COMPUTE,
    S_DONE
  } state_t;

  // state/k name the term on the outputs, or the pending term while stalled.
  state_t             state, state_nxt;
  logic [CNT_W-1:0]   k, k_nxt;
  logic               stalled, stalled_nxt;
  logic [CNT_W-1:0]   n_lat, n_lat_nxt;
  logic [IMM_W-1:0]   seed_a, seed_a_nxt;
  logic [IMM_W-1:0]   seed_b, seed_b_nxt;

  state_t             adv_state;
  logic [CNT_W-1:0]   adv_k;
  logic [SEL_W-1:0]   a_sel, b_sel, w_sel;

  logic [ALU_OP_W-1:0] alu_op_nxt;
  logic [MUX_W-1:0]    muxes_nxt;
  logic [NUM_REGS-1:0] regs_en_nxt;
  logic [IMM_W-1:0]    imm_nxt;
  logic [CNT_W-1:0]    term_idx_nxt;
  logic                busy_nxt;
  logic                done_nxt;

  // Successor of the term currently being written.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    adv_state = S_DONE;
    adv_k     = k;
    unique case (state)
      S_SEED0: begin
        if (n_lat != CNT_W'(1)) begin
          adv_state = S_SEED1;
          adv_k     = CNT_W'(1);
        end
      end
      S_SEED1: begin
        if (n_lat != CNT_W'(2)) begin
          adv_state = S_COMPUTE;
          adv_k     = CNT_W'(2);
        end
      end
      S_COMPUTE: begin
        if (k != n_lat - CNT_W'(1)) begin
          adv_state = S_COMPUTE;
          adv_k     = k + CNT_W'(1);
        end
      end
      default: begin
        adv_state = S_DONE;
        adv_k     = k;
      end
    endcase
  end

  // Next-state logic: start handshake, run sequencing and stall.
  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    stalled_nxt = 1'b0;
    n_lat_nxt   = n_lat;
    seed_a_nxt  = seed_a;
    seed_b_nxt  = seed_b;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          n_lat_nxt = n_terms;
          k_nxt     = '0;
          unique case (mode)
            2'd1: begin
              seed_a_nxt = IMM_W'(2);
              seed_b_nxt = IMM_W'(1);
            end
            2'd2: begin
              seed_a_nxt = seed0;
              seed_b_nxt = seed1;
            end
            default: begin
              seed_a_nxt = IMM_W'(0);
              seed_b_nxt = IMM_W'(1);
            end
          endcase
          state_nxt = (n_terms == '0) ? S_DONE : S_SEED0;
        end
      end
      S_SEED0, S_SEED1, S_COMPUTE: begin
        if (stalled) begin
          // Pending term not yet issued: keep it until hold drops.
          stalled_nxt = hold;
        end else begin
          state_nxt   = adv_state;
          k_nxt       = adv_k;
          stalled_nxt = hold && (adv_state != S_DONE);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign a_sel = SEL_W'(k_nxt - CNT_W'(2));
  assign b_sel = SEL_W'(k_nxt - CNT_W'(1));
  assign w_sel = SEL_W'(k_nxt);

  // Control word for the next cycle, derived from the next state so outputs stay registered.
  always_comb begin
    alu_op_nxt   = OP_NOP;
    muxes_nxt    = '0;
    regs_en_nxt  = '0;
    imm_nxt      = '0;
    term_idx_nxt = term_idx;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;

    if (stalled_nxt) begin
      busy_nxt     = 1'b1;
      term_idx_nxt = k_nxt;
    end else begin
      unique case (state_nxt)
        S_SEED0: begin
          alu_op_nxt       = OP_MOVI;
          muxes_nxt[2*SEL_W] = 1'b1;
          imm_nxt          = seed_a_nxt;
          regs_en_nxt[0]   = 1'b1;
          term_idx_nxt     = k_nxt;
          busy_nxt         = 1'b1;
        end
        S_SEED1: begin
          alu_op_nxt       = OP_MOVI;
          muxes_nxt[2*SEL_W] = 1'b1;
          imm_nxt          = seed_b_nxt;
          regs_en_nxt[1]   = 1'b1;
          term_idx_nxt     = k_nxt;
          busy_nxt         = 1'b1;
        end
        S_COMPUTE: begin
          alu_op_nxt         = OP_ADD;
          muxes_nxt          = {1'b0, a_sel, b_sel};
          regs_en_nxt[w_sel] = 1'b1;
          term_idx_nxt       = k_nxt;
          busy_nxt           = 1'b1;
        end
        S_DONE:  done_nxt = 1'b1;
        default: done_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      k        <= '0;
      stalled  <= 1'b0;
      n_lat    <= '0;
      seed_a   <= '0;
      seed_b   <= '0;
      alu_op   <= OP_NOP;
      muxes    <= '0;
      regs_en  <= '0;
      imm      <= '0;
      term_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values and updates together.
      state    <= state_nxt;
      k        <= k_nxt;
      stalled  <= stalled_nxt;
      n_lat    <= n_lat_nxt;
      seed_a   <= seed_a_nxt;
      seed_b   <= seed_b_nxt;
      alu_op   <= alu_op_nxt;
      muxes    <= muxes_nxt;
      regs_en  <= regs_en_nxt;
      imm      <= imm_nxt;
      term_idx <= term_idx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: directed table, hand-written reset sequence,
// and randomized runs against a term-list reference model.
`timescale 1ns/1ps

module tb_fib_seq_ctrl;

  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  n_terms = '0;
  logic [1:0]  mode = '0;
  logic [15:0] seed0 = '0;
  logic [15:0] seed1 = '0;
  logic [7:0]  alu_op;
  logic [8:0]  muxes;
  logic [15:0] regs_en;
  logic [15:0] imm;
  logic [7:0]  term_idx;
  logic        busy;
  logic        done;

  fib_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .n_terms(n_terms), .mode(mode), .seed0(seed0), .seed1(seed1),
    .alu_op(alu_op), .muxes(muxes), .regs_en(regs_en), .imm(imm),
    .term_idx(term_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  alu;
    logic [8:0]  mux;
    logic [15:0] en;
    logic [15:0] imm;
    logic [7:0]  tidx;
    logic        busy;
    logic        done;
  } word_t;

  typedef struct {
    int n;
    int mode;
    int s0;
    int s1;
    int hold_at;
    int hold_len;
    int exp_cycles;
  } vec_t;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] last_tidx = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic word_t dut_word();
    return {alu_op, muxes, regs_en, imm, term_idx, busy, done};
  endfunction

  // Expected word for term k of a run, straight from the term rules.
  function automatic word_t term_word(int k, int sa, int sb);
    word_t w;
    w      = '0;
    w.busy = 1'b1;
    w.tidx = 8'(k);
    if (k < 2) begin
      w.alu = 8'h0B;
      w.mux = 9'h100;
      w.imm = (k == 0) ? 16'(sa) : 16'(sb);
      w.en  = 16'(1) << k;
    end else begin
      w.alu = 8'h05;
      w.mux = {1'b0, 4'((k - 2) % NR), 4'((k - 1) % NR)};
      w.en  = 16'(1) << (k % NR);
    end
    return w;
  endfunction

  task automatic run_seq(input vec_t v, output int cycles);
    word_t exp_q[$];
    bit    hold_q[$];
    word_t w;
    int    sa, sb;
    case (v.mode)
      1:       begin sa = 2;    sb = 1;    end
      2:       begin sa = v.s0; sb = v.s1; end
      default: begin sa = 0;    sb = 1;    end
    endcase
    for (int k = 0; k < v.n; k++) begin
      if (v.hold_len > 0 && k == v.hold_at) begin
        for (int h = 0; h < v.hold_len; h++) begin
          w = '0; w.busy = 1'b1; w.tidx = 8'(k);
          exp_q.push_back(w); hold_q.push_back(1'b1);
        end
      end
      exp_q.push_back(term_word(k, sa, sb)); hold_q.push_back(1'b0);
    end
    if (v.n > 0) last_tidx = 8'(v.n - 1);
    w = '0; w.tidx = last_tidx; w.done = 1'b1;
    exp_q.push_back(w); hold_q.push_back(1'b0);
    w.done = 1'b0;
    exp_q.push_back(w); hold_q.push_back(1'b0);

    @(negedge clk);
    n_terms = 8'(v.n); mode = 2'(v.mode); seed0 = 16'(v.s0); seed1 = 16'(v.s1);
    start = 1'b1;
    cycles = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      hold = hold_q[i];
      @(posedge clk);
      @(negedge clk);
      // Inputs scrambled mid-run and start retried while stalled must not disturb the run.
      start   = hold_q[i];
      n_terms = 8'($urandom); mode = 2'($urandom);
      seed0   = 16'($urandom); seed1 = 16'($urandom);
      check($sformatf("n=%0d mode=%0d cycle %0d word", v.n, v.mode, i), 64'(dut_word()), 64'(exp_q[i]));
      check($sformatf("n=%0d cycle %0d one-hot", v.n, i), 64'($countones(regs_en) <= 1), 64'd1);
      if (done && cycles < 0) cycles = i + 1;
    end
    hold  = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    int   cyc;

    tbl[0] = '{n: 16, mode: 0, s0: 0,  s1: 0,  hold_at: 0, hold_len: 0, exp_cycles: 17};
    tbl[1] = '{n: 20, mode: 0, s0: 0,  s1: 0,  hold_at: 0, hold_len: 0, exp_cycles: 21};
    tbl[2] = '{n: 0,  mode: 0, s0: 0,  s1: 0,  hold_at: 0, hold_len: 0, exp_cycles: 1};
    tbl[3] = '{n: 1,  mode: 0, s0: 0,  s1: 0,  hold_at: 0, hold_len: 0, exp_cycles: 2};
    tbl[4] = '{n: 2,  mode: 3, s0: 5,  s1: 6,  hold_at: 0, hold_len: 0, exp_cycles: 3};
    tbl[5] = '{n: 4,  mode: 1, s0: 0,  s1: 0,  hold_at: 0, hold_len: 0, exp_cycles: 5};
    tbl[6] = '{n: 3,  mode: 2, s0: 7,  s1: 9,  hold_at: 0, hold_len: 0, exp_cycles: 4};
    tbl[7] = '{n: 10, mode: 0, s0: 0,  s1: 0,  hold_at: 5, hold_len: 3, exp_cycles: 14};

    repeat (2) @(negedge clk);
    check("reset word", 64'(dut_word()), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle after reset", 64'(dut_word()), 64'd0);

    foreach (tbl[i]) begin
      run_seq(tbl[i], cyc);
      check($sformatf("table %0d run length", i), 64'(cyc), 64'(tbl[i].exp_cycles));
    end

    // Reset mid-COMPUTE: outputs clear asynchronously, then a fresh run works.
    @(negedge clk);
    n_terms = 8'd20; mode = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("busy before reset", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1 check("async reset word", 64'(dut_word()), 64'd0);
    @(negedge clk);
    check("held in reset", 64'(dut_word()), 64'd0);
    reset = 1'b1;
    last_tidx = '0;
    v = '{n: 3, mode: 0, s0: 0, s1: 0, hold_at: 0, hold_len: 0, exp_cycles: 4};
    run_seq(v, cyc);
    check("run after reset length", 64'(cyc), 64'd4);

    for (int r = 0; r < 15; r++) begin
      v.n    = $urandom_range(0, 40);
      v.mode = $urandom_range(0, 3);
      v.s0   = $urandom_range(0, 65535);
      v.s1   = $urandom_range(0, 65535);
      v.hold_at = 0;
      v.hold_len = 0;
      if (v.n >= 2 && $urandom_range(0, 1) == 1) begin
        v.hold_at  = $urandom_range(1, v.n - 1);
        v.hold_len = $urandom_range(1, 4);
      end
      v.exp_cycles = v.n + v.hold_len + 1;
      run_seq(v, cyc);
      check($sformatf("random %0d run length", r), 64'(cyc), 64'(v.exp_cycles));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
